// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard port: receive FSM states,
// the CPU-visible address and the status bit positions in the read word.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [31:0] PS2_ADDR = 32'h0000_0FA8;

    localparam int RDATA_READY_BIT = 31;
    localparam int RDATA_OVF_BIT   = 30;
    localparam int RDATA_FERR_BIT  = 29;

endpackage

// File: rtl/ps2_fifo.sv
// Scan-code FIFO with a separate occupancy counter so full and empty differ.
// A pop frees the head slot in the same edge, so push+pop while full is lossless.
module ps2_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              drop
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              pop_en;
    logic              push_en;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);
    assign drop    = push & full & ~pop_en;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard_port.sv
// PS/2 keyboard receiver: synchronizes the raw lines, decodes 11-bit frames,
// buffers accepted scan codes and exposes a status/data word to the CPU.
module ps2_keyboard_port
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2Clk,
    input  logic        ps2Data,
    input  logic        rdEn,
    output logic [31:0] rdata,
    output logic        keyReady
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    ps2_state_t state, state_nxt;

    logic          clk_p0, clk_p1, clk_p2;
    logic          data_p0, data_p1, data_p2, data_p3;
    logic          fall_p3;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          parity_bit;
    logic [TW-1:0] tmo_cnt;
    logic          overflow;
    logic          frame_err;

    logic          clr_cnt, shift_en, par_en, push, err_set, tmo_hit;
    logic [7:0]    head;
    logic          empty;
    logic          drop;

    // Stage p0/p1: two-flop synchronizers, p2/p3: falling-edge detect and align
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_p0  <= 1'b1;
            clk_p1  <= 1'b1;
            clk_p2  <= 1'b1;
            data_p0 <= 1'b1;
            data_p1 <= 1'b1;
            data_p2 <= 1'b1;
            data_p3 <= 1'b1;
            fall_p3 <= 1'b0;
        end else begin
            clk_p0  <= ps2Clk;
            clk_p1  <= clk_p0;
            clk_p2  <= clk_p1;
            data_p0 <= ps2Data;
            data_p1 <= data_p0;
            data_p2 <= data_p1;
            data_p3 <= data_p2;
            fall_p3 <= clk_p2 & ~clk_p1;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_cnt   = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        push      = 1'b0;
        err_set   = 1'b0;
        tmo_hit   = (state != IDLE) && !fall_p3 && (tmo_cnt == TMO_LAST);
        case (state)
            IDLE: begin
                if (fall_p3 && !data_p3) begin
                    state_nxt = DATA;
                    clr_cnt   = 1'b1;
                end
            end
            DATA: begin
                if (fall_p3) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (fall_p3) begin
                    par_en    = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (fall_p3) begin
                    state_nxt = IDLE;
                    // Odd parity: data plus parity bit must hold an odd number of ones
                    if (data_p3 && (^{shreg, parity_bit})) push = 1'b1;
                    else                                   err_set = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (tmo_hit) begin
            state_nxt = IDLE;
            err_set   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            tmo_cnt    <= '0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clr_cnt)  bit_cnt <= '0;
            if (shift_en) begin
                shreg   <= {data_p3, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (par_en) parity_bit <= data_p3;
            if (state_nxt == IDLE || fall_p3) tmo_cnt <= '0;
            else                              tmo_cnt <= tmo_cnt + TW'(1);
            // Setting wins over the read-side clear
            if (drop)      overflow <= 1'b1;
            else if (rdEn) overflow <= 1'b0;
            if (err_set)   frame_err <= 1'b1;
            else if (rdEn) frame_err <= 1'b0;
        end
    end

    ps2_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (rdEn),
        .wdata (shreg),
        .head  (head),
        .empty (empty),
        .drop  (drop)
    );

    assign keyReady = ~empty;

    always_comb begin
        rdata                  = '0;
        rdata[RDATA_READY_BIT] = keyReady;
        rdata[RDATA_OVF_BIT]   = overflow;
        rdata[RDATA_FERR_BIT]  = frame_err;
        rdata[7:0]             = empty ? 8'h00 : head;
    end

endmodule

// File: tb/tb_ps2_keyboard_port.sv
// Directed bench for ps2_keyboard_port: bit-banged PS/2 frames with
// hand-computed expected status/data words.
module tb_ps2_keyboard_port;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2Clk = 1'b1;
    logic        ps2Data = 1'b1;
    logic        rdEn = 1'b0;
    logic [31:0] rdata;
    logic        keyReady;

    int total = 0;
    int bad = 0;

    ps2_keyboard_port #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2Clk   (ps2Clk),
        .ps2Data  (ps2Data),
        .rdEn     (rdEn),
        .rdata    (rdata),
        .keyReady (keyReady)
    );

    always #5 clk = ~clk;

    // Ends 4 clk edges after the stop-bit fall, ps2Clk left low.
    // rd_at_stop raises rdEn exactly on the push edge.
    task automatic send_frame(input logic [7:0] code, input logic par,
                              input logic stp, input logic rd_at_stop);
        logic [10:0] bits;
        bits = {stp, par, code, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2Data = bits[i];
            ps2Clk  = 1'b1;
            repeat (8) @(posedge clk);
            #1 ps2Clk = 1'b0;
            if (i < 10) begin
                repeat (8) @(posedge clk);
            end else begin
                repeat (3) @(posedge clk);
                #1;
                if (rd_at_stop) rdEn = 1'b1;
                @(posedge clk);
                #1 rdEn = 1'b0;
            end
        end
    endtask

    task automatic send_partial(input int ndata);
        logic [7:0] code;
        code = 8'h1C;
        for (int i = 0; i <= ndata; i++) begin
            ps2Data = (i == 0) ? 1'b0 : code[i-1];
            ps2Clk  = 1'b1;
            repeat (8) @(posedge clk);
            #1 ps2Clk = 1'b0;
            repeat (8) @(posedge clk);
        end
        #1 ps2Clk = 1'b1;
    endtask

    task automatic line_idle();
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic read_pulse();
        rdEn = 1'b1;
        @(posedge clk);
        #1 rdEn = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0);
        end
        total++;
        if (keyReady !== 1'b0) begin
            bad++;
            $display("FAIL reset_keyready: got %b want 0", keyReady);
        end
        rst_n = 1'b1;
        line_idle();
    endtask

    task automatic test_single();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        total++;
        if (keyReady !== 1'b1) begin
            bad++;
            $display("FAIL single_latency: got keyReady=%b want 1", keyReady);
        end
        total++;
        if (rdata !== 32'h8000001C) begin
            bad++;
            $display("FAIL single_rdata: got %h want %h", rdata, 32'h8000001C);
        end
        line_idle();
        read_pulse();
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL single_after_read: got %h want %h", rdata, 32'h0);
        end
    endtask

    task automatic test_empty_read();
        read_pulse();
        read_pulse();
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL empty_read: got %h want %h", rdata, 32'h0);
        end
    endtask

    task automatic test_parity_err();
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        total++;
        if (keyReady !== 1'b0) begin
            bad++;
            $display("FAIL parity_keyready: got %b want 0", keyReady);
        end
        total++;
        if (rdata !== 32'h20000000) begin
            bad++;
            $display("FAIL parity_rdata: got %h want %h", rdata, 32'h20000000);
        end
        line_idle();
        read_pulse();
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL parity_clear: got %h want %h", rdata, 32'h0);
        end
    endtask

    task automatic test_stop_err();
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        line_idle();
        total++;
        if (rdata !== 32'h20000000) begin
            bad++;
            $display("FAIL stop_rdata: got %h want %h", rdata, 32'h20000000);
        end
        read_pulse();
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL stop_clear: got %h want %h", rdata, 32'h0);
        end
    endtask

    task automatic test_set_wins();
        send_frame(8'h1C, 1'b1, 1'b1, 1'b1);
        total++;
        if (rdata !== 32'h20000000) begin
            bad++;
            $display("FAIL set_wins: got %h want %h", rdata, 32'h20000000);
        end
        line_idle();
        read_pulse();
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL set_wins_clear: got %h want %h", rdata, 32'h0);
        end
    endtask

    task automatic test_overflow();
        logic [7:0]  codes [5];
        logic        pars  [5];
        logic [31:0] exp_after [4];
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        pars  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_after = '{32'h8000001E, 32'h80000026, 32'h80000025, 32'h00000000};
        for (int i = 0; i < 5; i++) begin
            send_frame(codes[i], pars[i], 1'b1, 1'b0);
            line_idle();
        end
        total++;
        if (rdata !== 32'hC0000016) begin
            bad++;
            $display("FAIL ovf_status: got %h want %h", rdata, 32'hC0000016);
        end
        for (int i = 0; i < 4; i++) begin
            read_pulse();
            total++;
            if (rdata !== exp_after[i]) begin
                bad++;
                $display("FAIL ovf_read%0d: got %h want %h", i, rdata, exp_after[i]);
            end
        end
    endtask

    task automatic test_timeout();
        send_partial(5);
        repeat (TMO + 1) @(posedge clk);
        #1;
        total++;
        if (rdata !== 32'h20000000) begin
            bad++;
            $display("FAIL timeout_err: got %h want %h", rdata, 32'h20000000);
        end
        line_idle();
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        line_idle();
        total++;
        if (rdata !== 32'hA00000F0) begin
            bad++;
            $display("FAIL timeout_recover: got %h want %h", rdata, 32'hA00000F0);
        end
        read_pulse();
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL timeout_clear: got %h want %h", rdata, 32'h0);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0]  codes [4];
        logic        pars  [4];
        logic [31:0] exp_after [4];
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25};
        pars  = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_after = '{32'h80000026, 32'h80000025, 32'h8000002E, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            send_frame(codes[i], pars[i], 1'b1, 1'b0);
            line_idle();
        end
        total++;
        if (rdata !== 32'h80000016) begin
            bad++;
            $display("FAIL full_status: got %h want %h", rdata, 32'h80000016);
        end
        send_frame(8'h2E, 1'b1, 1'b1, 1'b1);
        total++;
        if (rdata !== 32'h8000001E) begin
            bad++;
            $display("FAIL full_pushpop: got %h want %h", rdata, 32'h8000001E);
        end
        line_idle();
        for (int i = 0; i < 4; i++) begin
            read_pulse();
            total++;
            if (rdata !== exp_after[i]) begin
                bad++;
                $display("FAIL full_read%0d: got %h want %h", i, rdata, exp_after[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        send_partial(5);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (rdata !== 32'h0 || keyReady !== 1'b0) begin
            bad++;
            $display("FAIL midreset_out: got %h/%b want %h/0", rdata, keyReady, 32'h0);
        end
        rst_n = 1'b1;
        line_idle();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        line_idle();
        total++;
        if (rdata !== 32'h8000001C) begin
            bad++;
            $display("FAIL midreset_frame: got %h want %h", rdata, 32'h8000001C);
        end
        read_pulse();
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL midreset_clear: got %h want %h", rdata, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_empty_read();
        test_parity_err();
        test_stop_err();
        test_set_wins();
        test_overflow();
        test_timeout();
        test_full_push_pop();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_port.md
PS2_KEYBOARD_PORT -- requirements
Module: ps2_keyboard_port

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the scan-code buffer depth in entries, a power of two and at least 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000, SHALL set the maximum clk cycles allowed between PS/2 falling edges inside a frame.
REQ-004 Port clk, input, 1 bit, SHALL be the system clock, 50 MHz nominal.
REQ-005 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-006 Port ps2Clk, input, 1 bit, SHALL be the raw, asynchronous PS/2 clock line from the keyboard.
REQ-007 Port ps2Data, input, 1 bit, SHALL be the raw, asynchronous PS/2 data line from the keyboard.
REQ-008 Port rdEn, input, 1 bit, SHALL be the CPU read strobe: the decoder data-select for address 0x0FA8 qualified by a CPU load, one cycle per read.
REQ-009 Port rdata, output, 32 bits, SHALL be the status/data word returned to the CPU read mux.
REQ-010 Port keyReady, output, 1 bit, SHALL be high while the FIFO is non-empty.

Function
REQ-011 ps2Clk and ps2Data SHALL each pass through a 2-flop synchronizer before any use.
REQ-012 A bit SHALL be sampled on the clk cycle after a synchronized ps2Clk 1->0 transition is detected.
REQ-013 The receive FSM SHALL have states IDLE, DATA, PARITY, STOP.
- IDLE: sampled 0 -> DATA, bit count cleared; sampled 1 -> remain in IDLE (glitch or line idle).
- DATA: shift 8 bits in, LSB first; after the 8th bit -> PARITY.
- PARITY: capture the parity bit -> STOP.
- STOP: always -> IDLE.
REQ-014 A frame SHALL be accepted only if the stop bit is 1 and the 8 data bits plus the parity bit have an odd count of ones.
REQ-015 An accepted frame SHALL push its 8-bit code into the FIFO on the cycle the stop bit is sampled.
REQ-016 A rejected frame SHALL be discarded and SHALL set sticky flag frameErr.
REQ-017 In any state other than IDLE, TIMEOUT_CYCLES clk cycles with no falling edge SHALL return the FSM to IDLE, discard the partial frame, and set frameErr.
REQ-018 rdata SHALL be formed combinationally as follows:
- bit 31: keyReady
- bit 30: overflow
- bit 29: frameErr
- bits 28:8: zero
- bits 7:0: FIFO head, or 0x00 when the FIFO is empty
REQ-019 On rdEn with the FIFO non-empty, the head entry SHALL be popped at that clk edge.
REQ-020 On rdEn with the FIFO empty, no pop SHALL occur and the occupancy SHALL stay at zero.
REQ-021 Any rdEn SHALL clear both overflow and frameErr at that clk edge.
REQ-022 If a set event and a clear occur in the same cycle, the set SHALL win.
REQ-023 On a push with the FIFO full and no simultaneous pop, the new code SHALL be dropped and overflow SHALL be set.
REQ-024 A push and a pop in the same cycle SHALL both take effect, with no overflow, including when the FIFO is full.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 Occupancy SHALL be tracked in log2(FIFO_DEPTH)+1 bits, so full and empty are distinct.
REQ-027 Receive latency SHALL be at most 4 clk cycles from the stop-bit falling edge on the raw pin to keyReady=1 (2 synchronizer cycles, 1 edge-detect cycle, 1 push cycle).

Reset
REQ-028 rst_n low SHALL asynchronously return the FSM to IDLE and clear the shift register, bit count, timeout counter, FIFO pointers, occupancy, overflow, frameErr and the synchronizer flops (to 1).
REQ-029 Under reset, outputs SHALL be keyReady=0 and rdata=0x00000000.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame, and reception SHALL restart at the next start bit after release.

Structure
REQ-031 Shared package ps2_pkg SHALL hold:
- the FSM state enum
- constant PS2_ADDR = 32'h0FA8
- bit-position constants for rdata bits 31, 30 and 29
REQ-032 The FIFO SHALL be a separate sub-module ps2_fifo, parameterized by depth and width and using the same clk/rst_n.
REQ-033 The remaining logic (synchronizers, edge detect, FSM, timeout counter and flags) SHALL reside in ps2_keyboard_port.

Verification
REQ-034 Sending frame 0x1C with parity 0 and stop 1 SHALL give keyReady=1 and rdata=0x8000001C within 4 cycles; one rdEn SHALL then give rdata=0x00000000.
REQ-035 Sending frame 0x1C with parity 1 SHALL push nothing, keyReady SHALL stay 0, and rdata SHALL be 0x20000000; the next rdEn SHALL clear it to 0x00000000.
REQ-036 Sending 5 valid frames (0x16, 0x1E, 0x26, 0x25, 0x2E) without reads SHALL give rdata=0xC0000016; 4 successive rdEn pulses SHALL return 0x16, 0x1E, 0x26, 0x25 in order, with overflow cleared after the first.
REQ-037 Stopping the line after 5 data bits and waiting TIMEOUT_CYCLES+1 SHALL set frameErr; a following valid 0xF0 frame SHALL be received correctly.
REQ-038 With the FIFO full, a stop-bit push coincident with rdEn SHALL leave occupancy 4, overflow 0, and the new code at the tail.
REQ-039 Asserting rst_n low mid-frame, then sending a valid 0x1C frame, SHALL give rdata=0x8000001C.
